// File: rtl/pixel_pkg.sv
// Shared types and constants for the 4x4 global-shutter pixel array sequencer.
package pixel_pkg;

  localparam int DW   = 8;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef logic [COLS-1:0][DW-1:0] pix_row_t;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_ERASE        = 3'd1,
    ST_EXPOSE       = 3'd2,
    ST_CONVERT      = 3'd3,
    ST_READ_SETTLE  = 3'd4,
    ST_READ_CAPTURE = 3'd5,
    ST_HOLD         = 3'd6,
    ST_DONE         = 3'd7
  } pix_state_t;

  // Sizes the shared phase counter from the longest timed phase.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pixel_conv_counter.sv
// Conversion ramp counter broadcast on the column buses, plus its bus enable.
module pixel_conv_counter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_i,   // next cycle is outside CONVERT: park at zero
  input  logic          en_i,    // staying in CONVERT: step the ramp
  input  logic          oe_i,    // next cycle is a CONVERT cycle
  output logic [DW-1:0] cnt_o,
  output logic          oe_o
);

  logic [DW-1:0] cnt_q;
  logic          oe_q;

  // Ramp steps once per CONVERT cycle after the first; it is cleared outside
  // CONVERT so every conversion begins at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      oe_q  <= 1'b0;
    end else begin
      oe_q <= oe_i;
      if (clr_i)     cnt_q <= '0;
      else if (en_i) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
  assign oe_o  = oe_q;

endmodule

// File: rtl/pixel_array_ctrl.sv
// Global-shutter frame sequencer: erase, expose, ramp conversion, then row-by-row
// readout with a valid/ready handshake. Every output is a register loaded from
// the next-state decode so that outputs line up with the state they belong to.
module pixel_array_ctrl #(
  parameter int ERASE_CYCLES   = 5,
  parameter int EXPOSE_CYCLES  = 255,
  parameter int CONVERT_CYCLES = 256,
  parameter int ROWS           = pixel_pkg::ROWS,
  parameter int COLS           = pixel_pkg::COLS,
  parameter int DW             = pixel_pkg::DW
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     erase,
  output logic [ROWS-1:0]          expose,
  output logic [ROWS-1:0]          read,
  output logic [DW-1:0]            cnt_out,
  output logic                     cnt_oe,
  input  logic [COLS-1:0][DW-1:0]  data_in,
  output logic [COLS-1:0][DW-1:0]  row_data,
  output logic [1:0]               row_idx,
  output logic                     row_valid,
  input  logic                     row_ready
);
  import pixel_pkg::*;

  localparam int PW = $clog2(max3(ERASE_CYCLES, EXPOSE_CYCLES, CONVERT_CYCLES)) + 1;
  localparam logic [PW-1:0] ERASE_LAST  = PW'(ERASE_CYCLES - 1);
  localparam logic [PW-1:0] EXPOSE_LAST = PW'(EXPOSE_CYCLES - 1);
  localparam logic [PW-1:0] CONV_LAST   = PW'(CONVERT_CYCLES - 1);
  localparam logic [1:0]    ROW_LAST    = 2'(ROWS - 1);

  pix_state_t              state_q, state_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [1:0]              row_q, row_d;
  logic [ROWS-1:0]         read_d;
  logic                    accept;

  logic                    busy_q, frame_done_q, erase_q, row_valid_q;
  logic [ROWS-1:0]         expose_q, read_q;
  logic [COLS-1:0][DW-1:0] row_data_q;
  logic [1:0]              row_idx_q;

  assign accept = row_valid_q & row_ready;

  // Next-state decode; the phase counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      ST_IDLE:         if (start) state_d = ST_ERASE;
      ST_ERASE:        if (phase_q == ERASE_LAST) state_d = ST_EXPOSE;
      ST_EXPOSE:       if (phase_q == EXPOSE_LAST) state_d = ST_CONVERT;
      ST_CONVERT: begin
        if (phase_q == CONV_LAST) begin
          state_d = ST_READ_SETTLE;
          row_d   = 2'd0;
        end
      end
      ST_READ_SETTLE:  state_d = ST_READ_CAPTURE;
      ST_READ_CAPTURE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (accept) begin
          if (row_q == ROW_LAST) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + 2'd1;
            state_d = ST_READ_SETTLE;
          end
        end
      end
      ST_DONE:         state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
    phase_d = (state_d != state_q) ? '0 : phase_q + 1'b1;
    read_d  = (state_d == ST_READ_SETTLE || state_d == ST_READ_CAPTURE)
              ? (ROWS'(1) << row_d) : '0;
  end

  // Sequencer state and registered array controls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      row_q        <= 2'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      erase_q      <= 1'b0;
      expose_q     <= '0;
      read_q       <= '0;
      row_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      row_q        <= row_d;
      busy_q       <= (state_d != ST_IDLE);
      frame_done_q <= (state_d == ST_DONE);
      erase_q      <= (state_d == ST_ERASE);
      expose_q     <= {ROWS{state_d == ST_EXPOSE}};
      read_q       <= read_d;
      row_valid_q  <= (state_d == ST_HOLD);
    end
  end

  // Row capture: the bus has settled by the second READ cycle; the value is
  // held until the next capture so it stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row_data_q <= '0;
      row_idx_q  <= 2'd0;
    end else if (state_q == ST_READ_CAPTURE) begin
      row_data_q <= data_in;
      row_idx_q  <= row_q;
    end
  end

  pixel_conv_counter #(.DW(DW)) u_conv (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (state_d != ST_CONVERT),
    .en_i    (state_q == ST_CONVERT && state_d == ST_CONVERT),
    .oe_i    (state_d == ST_CONVERT),
    .cnt_o   (cnt_out),
    .oe_o    (cnt_oe)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign erase      = erase_q;
  assign expose     = expose_q;
  assign read       = read_q;
  assign row_valid  = row_valid_q;
  assign row_data   = row_data_q;
  assign row_idx    = row_idx_q;

endmodule
